fetch_ctrl: RTL and testbench

Sequencer for the program counter of the single-cycle RV32I core. It owns the PC register and selects the next PC from sequential (PC+4), branch/jump redirect, or hold. It also generates the stall and write-back gating for multi-cycle loads and instruction-memory wait states. It sits between the instruction memory, the branch unit and the register file write port.

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_ctrl_if.sv | 26 ++
 rtl/fetch_ctrl_pc_next_sel.sv | 30 +++
 rtl/fetch_ctrl.sv | 118 +++++++++++
 tb/tb_fetch_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/PC sequencer.
//   state_e  : sequencer states (RUN / LOAD_WAIT / IMEM_WAIT)
//   pc_sel_e : next-PC source select (hold / +4 / redirect)
//   OPC_LOAD : major opcode shared by LB/LH/LW/LBU/LHU
//   INST_ALIGN : forced low bits of any instruction address
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_IMEM_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [1:0] INST_ALIGN = 2'b00;

  function automatic logic is_load(input logic [6:0] opcode);
    return opcode == OPC_LOAD;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Bus bundle between the fetch sequencer and its surroundings
// (instruction memory, branch unit, register-file write port).
//   slave  : view used by fetch_ctrl (consumes i_*, drives o_*)
//   master : view used by the surrounding core / bench
interface fetch_ctrl_if;
  logic [31:0] i_inst;
  logic        i_imem_ready;
  logic        i_br_taken;
  logic [31:0] i_br_target;
  logic [31:0] o_pc;
  logic [31:0] o_pc_four;
  logic        o_inst_valid;
  logic        o_stall;
  logic        o_wb_en;
  logic        o_misalign;

  modport slave (
    input  i_inst, i_imem_ready, i_br_taken, i_br_target,
    output o_pc, o_pc_four, o_inst_valid, o_stall, o_wb_en, o_misalign
  );

  modport master (
    output i_inst, i_imem_ready, i_br_taken, i_br_target,
    input  o_pc, o_pc_four, o_inst_valid, o_stall, o_wb_en, o_misalign
  );
endinterface

// File: rtl/fetch_ctrl_pc_next_sel.sv
// Combinational next-PC selection.
//   i_pc                : current PC
//   i_sel               : hold / +4 / redirect
//   i_target            : redirect target (low bits masked off here)
//   o_next_pc           : selected next PC
//   o_pc_four           : i_pc + 4 (32-bit wrap)
//   o_target_misaligned : i_target low bits were non-zero
module pc_next_sel
  import fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  pc_sel_e     i_sel,
  input  logic [31:0] i_target,
  output logic [31:0] o_next_pc,
  output logic [31:0] o_pc_four,
  output logic        o_target_misaligned
);

  always_comb begin
    o_pc_four           = i_pc + 32'd4;
    o_target_misaligned = (i_target[1:0] != INST_ALIGN);
    o_next_pc           = i_pc;
    case (i_sel)
      PC_INC:      o_next_pc = o_pc_four;
      PC_REDIRECT: o_next_pc = {i_target[31:2], INST_ALIGN};
      default:     o_next_pc = i_pc;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// PC sequencer for the single-cycle RV32I core. Owns the PC register,
// selects sequential / redirect / hold, stalls for multi-cycle loads and
// instruction-memory wait states, and gates register-file write-back.
//   i_clk   : clock
//   i_reset : asynchronous, active-low reset
//   bus     : fetch_ctrl_if.slave (instruction, imem ready, branch
//             redirect in; pc, pc+4, inst_valid, stall, wb_en, misalign out)
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR      = 32'h0000_0000,
  parameter int unsigned LOAD_STALL_CYCLES = 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  fetch_ctrl_if.slave  bus
);

  localparam logic [3:0] LOAD_CNT_INIT = 4'(LOAD_STALL_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        misalign_q, misalign_d;

  pc_sel_e     pc_sel;
  logic [31:0] pc_four;
  logic        target_misaligned;
  logic        inst_valid, stall, wb_en;

  // Only the opcode field is decoded here.
  logic        inst_hi_unused;
  assign inst_hi_unused = ^bus.i_inst[31:7];

  pc_next_sel u_pc_next_sel (
    .i_pc                (pc_q),
    .i_sel               (pc_sel),
    .i_target            (bus.i_br_target),
    .o_next_pc           (pc_d),
    .o_pc_four           (pc_four),
    .o_target_misaligned (target_misaligned)
  );

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      cnt_q      <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    misalign_d = misalign_q;
    pc_sel     = PC_HOLD;
    inst_valid = 1'b0;
    stall      = 1'b1;
    wb_en      = 1'b0;

    case (state_q)
      ST_RUN: begin
        inst_valid = bus.i_imem_ready;
        if (!bus.i_imem_ready) begin
          state_d = ST_IMEM_WAIT;
        end else if (bus.i_br_taken) begin
          // Redirect takes precedence over a load in the same slot.
          pc_sel = PC_REDIRECT;
          stall  = 1'b0;
          wb_en  = 1'b1;
          if (target_misaligned) misalign_d = 1'b1;
        end else if (is_load(bus.i_inst[6:0])) begin
          cnt_d   = LOAD_CNT_INIT;
          state_d = ST_LOAD_WAIT;
        end else begin
          pc_sel = PC_INC;
          stall  = 1'b0;
          wb_en  = 1'b1;
        end
      end

      ST_LOAD_WAIT: begin
        // Instruction held stable; memory/branch inputs are ignored here.
        inst_valid = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          pc_sel  = PC_INC;
          stall   = 1'b0;
          wb_en   = 1'b1;
          state_d = ST_RUN;
        end
      end

      ST_IMEM_WAIT: begin
        // Return to RUN without advancing so the instruction is decoded there.
        if (bus.i_imem_ready) state_d = ST_RUN;
      end

      default: state_d = ST_RUN;
    endcase
  end

  assign bus.o_pc         = pc_q;
  assign bus.o_pc_four    = pc_four;
  assign bus.o_inst_valid = inst_valid;
  assign bus.o_stall      = stall;
  // No write-back may escape while reset is held.
  assign bus.o_wb_en      = wb_en & i_reset;
  assign bus.o_misalign   = misalign_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fetch_ctrl_if bus1 ();
  fetch_ctrl_if bus3 ();

  fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .LOAD_STALL_CYCLES(1)) dut1 (
    .i_clk(clk), .i_reset(rst_n), .bus(bus1));
  fetch_ctrl #(.RESET_VECTOR(32'h0000_0000), .LOAD_STALL_CYCLES(3)) dut3 (
    .i_clk(clk), .i_reset(rst_n), .bus(bus3));

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] LW   = 32'h0000_2003;
  localparam logic [31:0] LBU  = 32'h0000_4083;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: per-instance latency bookkeeping.
  int          lsc [2] = '{1, 3};
  logic [31:0] m_pc [2];
  int          m_left [2];   // remaining load-hold cycles after the decode cycle
  bit          m_memw [2];   // waiting for instruction memory
  bit          m_mis [2];
  logic [31:0] n_pc [2];
  int          n_left [2];
  bit          n_memw [2];
  bit          n_mis [2];

  typedef struct {
    logic [31:0] inst;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] e_pc;
    logic        e_v;
    logic        e_s;
    logic        e_w;
    logic        e_m;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 32'h0; m_left[k] = 0; m_memw[k] = 0; m_mis[k] = 0;
    end
  endtask

  task automatic model_eval(input int k, input logic [31:0] inst, input logic rdy,
                            input logic br, input logic [31:0] tgt,
                            output logic e_v, output logic e_s, output logic e_w);
    n_pc[k] = m_pc[k]; n_left[k] = m_left[k]; n_memw[k] = m_memw[k]; n_mis[k] = m_mis[k];
    e_v = 0; e_s = 1; e_w = 0;
    if (m_memw[k]) begin
      if (rdy) n_memw[k] = 0;
    end else if (m_left[k] > 0) begin
      e_v = 1;
      n_left[k] = m_left[k] - 1;
      if (m_left[k] == 1) begin
        e_s = 0; e_w = 1; n_pc[k] = m_pc[k] + 32'd4;
      end
    end else if (!rdy) begin
      n_memw[k] = 1;
    end else begin
      e_v = 1;
      if (br) begin
        e_s = 0; e_w = 1;
        n_pc[k] = tgt & 32'hFFFF_FFFC;
        if (tgt % 4 != 0) n_mis[k] = 1;
      end else if (inst[6:0] == 7'h03) begin
        n_left[k] = lsc[k];
      end else begin
        e_s = 0; e_w = 1; n_pc[k] = m_pc[k] + 32'd4;
      end
    end
  endtask

  task automatic get_out(input int k, output logic [31:0] pc, output logic [31:0] pcf,
                         output logic v, output logic s, output logic w, output logic m);
    if (k == 0) begin
      pc = bus1.o_pc; pcf = bus1.o_pc_four; v = bus1.o_inst_valid;
      s = bus1.o_stall; w = bus1.o_wb_en; m = bus1.o_misalign;
    end else begin
      pc = bus3.o_pc; pcf = bus3.o_pc_four; v = bus3.o_inst_valid;
      s = bus3.o_stall; w = bus3.o_wb_en; m = bus3.o_misalign;
    end
  endtask

  task automatic apply(input logic [31:0] inst, input logic rdy, input logic br,
                       input logic [31:0] tgt);
    bus1.i_inst = inst; bus1.i_imem_ready = rdy; bus1.i_br_taken = br; bus1.i_br_target = tgt;
    bus3.i_inst = inst; bus3.i_imem_ready = rdy; bus3.i_br_taken = br; bus3.i_br_target = tgt;
    #1;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a_pc, a_pf;
      logic a_v, a_s, a_w, a_m, e_v, e_s, e_w;
      get_out(k, a_pc, a_pf, a_v, a_s, a_w, a_m);
      model_eval(k, inst, rdy, br, tgt, e_v, e_s, e_w);
      check($sformatf("model_pc[lsc%0d]", lsc[k]), a_pc, m_pc[k]);
      check($sformatf("model_pc_four[lsc%0d]", lsc[k]), a_pf, m_pc[k] + 32'd4);
      check($sformatf("model_valid[lsc%0d]", lsc[k]), 32'(a_v), 32'(e_v));
      check($sformatf("model_stall[lsc%0d]", lsc[k]), 32'(a_s), 32'(e_s));
      check($sformatf("model_wb_en[lsc%0d]", lsc[k]), 32'(a_w), 32'(e_w));
      check($sformatf("model_misalign[lsc%0d]", lsc[k]), 32'(a_m), 32'(m_mis[k]));
    end
  endtask

  task automatic advance();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = n_pc[k]; m_left[k] = n_left[k]; m_memw[k] = n_memw[k]; m_mis[k] = n_mis[k];
    end
    @(negedge clk);
  endtask

  task automatic step(input logic [31:0] inst, input logic rdy, input logic br,
                      input logic [31:0] tgt);
    apply(inst, rdy, br, tgt);
    advance();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_pc1", bus1.o_pc, 32'h0);
    check("rst_pc3", bus3.o_pc, 32'h0);
    check("rst_wb1", 32'(bus1.o_wb_en), 32'h0);
    check("rst_mis1", 32'(bus1.o_misalign), 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus1.i_inst = ADDI; bus1.i_imem_ready = 1'b1; bus1.i_br_taken = 1'b0; bus1.i_br_target = '0;
    bus3.i_inst = ADDI; bus3.i_imem_ready = 1'b1; bus3.i_br_taken = 1'b0; bus3.i_br_target = '0;

    // Vector table for the LOAD_STALL_CYCLES=1 instance.
    //          inst  rdy  br   tgt            pc            v  s  w  mis
    vecs[0]  = '{ADDI, 1'b1, 1'b0, 32'h0,        32'h0000_0000, 1, 0, 1, 0};
    vecs[1]  = '{ADDI, 1'b1, 1'b0, 32'h0,        32'h0000_0004, 1, 0, 1, 0};
    vecs[2]  = '{LW,   1'b1, 1'b0, 32'h0,        32'h0000_0008, 1, 1, 0, 0};
    vecs[3]  = '{LW,   1'b0, 1'b1, 32'h40,       32'h0000_0008, 1, 0, 1, 0};
    vecs[4]  = '{ADDI, 1'b1, 1'b0, 32'h0,        32'h0000_000C, 1, 0, 1, 0};
    vecs[5]  = '{LBU,  1'b1, 1'b1, 32'h100,      32'h0000_0010, 1, 0, 1, 0};
    vecs[6]  = '{ADDI, 1'b1, 1'b1, 32'h203,      32'h0000_0100, 1, 0, 1, 0};
    vecs[7]  = '{ADDI, 1'b0, 1'b0, 32'h0,        32'h0000_0200, 0, 1, 0, 1};
    vecs[8]  = '{ADDI, 1'b0, 1'b0, 32'h0,        32'h0000_0200, 0, 1, 0, 1};
    vecs[9]  = '{ADDI, 1'b1, 1'b0, 32'h0,        32'h0000_0200, 0, 1, 0, 1};
    vecs[10] = '{ADDI, 1'b1, 1'b0, 32'h0,        32'h0000_0200, 1, 0, 1, 1};
    vecs[11] = '{ADDI, 1'b1, 1'b0, 32'h0,        32'h0000_0204, 1, 0, 1, 1};

    #2;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].inst, vecs[i].rdy, vecs[i].br, vecs[i].tgt);
      check($sformatf("vec%0d_pc", i), bus1.o_pc, vecs[i].e_pc);
      check($sformatf("vec%0d_valid", i), 32'(bus1.o_inst_valid), 32'(vecs[i].e_v));
      check($sformatf("vec%0d_stall", i), 32'(bus1.o_stall), 32'(vecs[i].e_s));
      check($sformatf("vec%0d_wb_en", i), 32'(bus1.o_wb_en), 32'(vecs[i].e_w));
      check($sformatf("vec%0d_misalign", i), 32'(bus1.o_misalign), 32'(vecs[i].e_m));
      advance();
    end

    // Three-cycle load stall at PC 0.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      apply(LW, 1'b1, 1'b0, 32'h0);
      check($sformatf("ld3_pc%0d", i), bus3.o_pc, 32'h0);
      check($sformatf("ld3_wb%0d", i), 32'(bus3.o_wb_en), (i == 3) ? 32'h1 : 32'h0);
      check($sformatf("ld3_stall%0d", i), 32'(bus3.o_stall), (i == 3) ? 32'h0 : 32'h1);
      advance();
    end
    apply(ADDI, 1'b1, 1'b0, 32'h0);
    check("ld3_after_pc", bus3.o_pc, 32'h4);
    advance();

    // 32-bit wrap of the sequential PC.
    do_reset();
    step(ADDI, 1'b1, 1'b1, 32'hFFFF_FFFC);
    apply(ADDI, 1'b1, 1'b0, 32'h0);
    check("wrap_pc", bus1.o_pc, 32'hFFFF_FFFC);
    check("wrap_pc_four", bus1.o_pc_four, 32'h0);
    advance();
    apply(ADDI, 1'b1, 1'b0, 32'h0);
    check("wrap_pc_next", bus1.o_pc, 32'h0);
    advance();

    // Reset asserted mid-LOAD_WAIT at PC 0x20 with the misalign flag set.
    do_reset();
    step(ADDI, 1'b1, 1'b1, 32'h23);
    step(LW, 1'b1, 1'b0, 32'h0);
    bus1.i_inst = LW; bus3.i_inst = LW;
    #1;
    check("mid_ld_pc_before", bus1.o_pc, 32'h20);
    check("mid_ld_mis_before", 32'(bus1.o_misalign), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_pc1", bus1.o_pc, 32'h0);
    check("mid_rst_pc3", bus3.o_pc, 32'h0);
    check("mid_rst_wb1", 32'(bus1.o_wb_en), 32'h0);
    check("mid_rst_wb3", 32'(bus3.o_wb_en), 32'h0);
    check("mid_rst_mis1", 32'(bus1.o_misalign), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    apply(ADDI, 1'b1, 1'b0, 32'h0);
    check("post_rst_stall1", 32'(bus1.o_stall), 32'h0);
    advance();

    // Randomized traffic against the reference model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] inst, tgt;
      logic rdy, br;
      inst = ($urandom_range(3) == 0) ? LW : ((($urandom_range(7)) == 0) ? LBU : ADDI);
      rdy  = ($urandom_range(9) < 8);
      br   = ($urandom_range(4) == 0);
      tgt  = $urandom;
      if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
      step(inst, rdy, br, tgt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
